instr_fetch_unit: RTL and testbench



---
 rtl/proc_pkg.sv | 33 +++
 rtl/instr_fetch_unit_if.sv | 31 +++
 rtl/pc_reg.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: widths, opcodes, PC-select codes
// and the fetch FSM state encoding.
package proc_pkg;

    localparam int PC_W    = 6;
    localparam int INSTR_W = 20;

    localparam logic [3:0] OP_RST   = 4'b0010;
    localparam logic [3:0] OP_WRITE = 4'b0011;
    localparam logic [3:0] OP_LOADI = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_LOAD  = 4'b0110;
    localparam logic [3:0] OP_MV    = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_INC   = 4'b1001;
    localparam logic [3:0] OP_SUB   = 4'b1010;
    localparam logic [3:0] OP_JMPZ  = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1101;

    localparam logic [1:0] PCS_HOLD = 2'b00;
    localparam logic [1:0] PCS_INC  = 2'b01;
    localparam logic [1:0] PCS_JMP  = 2'b10;
    localparam logic [1:0] PCS_RST  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_CAPT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch unit, the control unit and the
// instruction memory read port.
interface instr_fetch_unit_if;
    import proc_pkg::*;

    logic               pc_we;
    logic [1:0]         pc_sel;
    logic [PC_W-1:0]    gamma;
    logic               fetch_req;
    logic               imem_rd;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               busy;
    logic [PC_W-1:0]    pc;
    logic               pc_wrap;

    modport slave (
        input  pc_we, pc_sel, gamma, fetch_req, imem_rdata,
        output imem_rd, imem_addr, instruction, instr_valid,
        output busy, pc, pc_wrap
    );

    modport master (
        output pc_we, pc_sel, gamma, fetch_req, imem_rdata,
        input  imem_rd, imem_addr, instruction, instr_valid,
        input  busy, pc, pc_wrap
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter with next-PC select and a sticky flag set when
// an increment rolls over from all-ones to zero.
module pc_reg
    import proc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [1:0]      i_sel,
    input  logic [PC_W-1:0] i_gamma,
    output logic [PC_W-1:0] o_pc,
    output logic            o_wrap
);

    logic [PC_W-1:0] r_pc;
    logic            r_wrap;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_wrap_set;

    always_comb begin
        w_pc_nxt   = r_pc;
        w_wrap_set = 1'b0;
        if (i_we) begin
            unique case (i_sel)
                PCS_HOLD: w_pc_nxt = r_pc;
                PCS_INC: begin
                    w_pc_nxt   = r_pc + 1'b1;
                    w_wrap_set = &r_pc;
                end
                PCS_JMP:  w_pc_nxt = i_gamma;
                PCS_RST:  w_pc_nxt = RESET_PC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_wrap <= 1'b0;
        end else begin
            r_pc   <= w_pc_nxt;
            r_wrap <= r_wrap | w_wrap_set;
        end
    end

    assign o_pc   = r_pc;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one memory read per request and
// latches the returned word into the instruction register.
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int              MEM_LAT  = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.slave  bus
);

    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [1:0]         r_cnt;
    logic [1:0]         w_cnt_nxt;
    logic [PC_W-1:0]    r_addr;
    logic [PC_W-1:0]    w_addr_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [PC_W-1:0]    w_pc;
    logic               w_wrap;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .i_we    (bus.pc_we),
        .i_sel   (bus.pc_sel),
        .i_gamma (bus.gamma),
        .o_pc    (w_pc),
        .o_wrap  (w_wrap)
    );

    // Address is latched from the pre-update PC, so a simultaneous
    // pc_we never changes which word this fetch returns.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_instr_nxt = r_instr;
        w_valid_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.fetch_req) begin
                    w_addr_nxt  = w_pc;
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (r_cnt == 2'd0) w_state_nxt = ST_CAPT;
                else               w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == 2'd1) w_state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
                w_instr_nxt = bus.imem_rdata;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.imem_rd     = (r_state == ST_READ);
    assign bus.imem_addr   = r_addr;
    assign bus.instruction = r_instr;
    assign bus.instr_valid = r_valid;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.pc          = w_pc;
    assign bus.pc_wrap     = w_wrap;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench: three fetch units (MEM_LAT 1,2,3) share one stimulus and
// are each compared every cycle against a transaction-level model.
module tb_instr_fetch_unit;
    import proc_pkg::*;

    logic        clk;
    logic        rst;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [5:0]  gamma;
    logic        fetch_req;
    bit          chk_en;
    int          tot;
    int          bad;

    logic [19:0] mem [64];

    logic [5:0]  o_pc    [3];
    logic        o_wrap  [3];
    logic [19:0] o_instr [3];
    logic        o_valid [3];
    logic        o_rd    [3];
    logic [5:0]  o_addr  [3];
    logic        o_busy  [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int L = g + 1;

        instr_fetch_unit_if ifc ();

        assign ifc.pc_we     = pc_we;
        assign ifc.pc_sel    = pc_sel;
        assign ifc.gamma     = gamma;
        assign ifc.fetch_req = fetch_req;

        instr_fetch_unit #(
            .MEM_LAT  (L),
            .RESET_PC (6'd0)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc.slave)
        );

        // memory returns data L cycles after the read strobe
        logic [19:0] pipe [4];
        always @(posedge clk) begin
            pipe[0] <= ifc.imem_rd ? mem[ifc.imem_addr] : 20'hBAD00;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign ifc.imem_rdata = pipe[L-1];

        assign o_pc[g]    = ifc.pc;
        assign o_wrap[g]  = ifc.pc_wrap;
        assign o_instr[g] = ifc.instruction;
        assign o_valid[g] = ifc.instr_valid;
        assign o_rd[g]    = ifc.imem_rd;
        assign o_addr[g]  = ifc.imem_addr;
        assign o_busy[g]  = ifc.busy;

        int          m_pc    = 0;
        bit          m_wrap  = 0;
        logic [19:0] m_instr = 20'h0;
        bit          m_valid = 0;
        bit          m_rd    = 0;
        bit          m_pend  = 0;
        int          m_addr  = 0;
        int          m_done  = 0;
        int          ne      = 0;
        bit          acc;
        bit          mis;

        initial begin
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    mis = (ifc.pc !== 6'(m_pc))
                       || (ifc.pc_wrap !== m_wrap)
                       || (ifc.instruction !== m_instr)
                       || (ifc.instr_valid !== m_valid)
                       || (ifc.imem_rd !== m_rd)
                       || (ifc.imem_addr !== 6'(m_addr))
                       || (ifc.busy !== m_pend);
                    tot++;
                    if (mis) begin
                        bad++;
                        $display({"FAIL cyc lat%0d edge%0d (got/exp):",
                                  " pc %0d/%0d wrap %0b/%0b",
                                  " instr %h/%h vld %0b/%0b rd %0b/%0b",
                                  " addr %0d/%0d busy %0b/%0b"},
                                 L, ne, ifc.pc, m_pc,
                                 ifc.pc_wrap, m_wrap,
                                 ifc.instruction, m_instr,
                                 ifc.instr_valid, m_valid,
                                 ifc.imem_rd, m_rd,
                                 ifc.imem_addr, m_addr,
                                 ifc.busy, m_pend);
                    end
                end
                if (rst) begin
                    m_pc = 0; m_wrap = 0; m_instr = 20'h0;
                    m_valid = 0; m_rd = 0; m_pend = 0; m_addr = 0;
                end else begin
                    acc = !m_pend && fetch_req;
                    m_valid = 0;
                    m_rd = 0;
                    if (m_pend && ne == m_done) begin
                        m_instr = mem[m_addr];
                        m_valid = 1;
                        m_pend = 0;
                    end
                    if (acc) begin
                        m_pend = 1;
                        m_addr = m_pc;
                        m_done = ne + L + 1;
                        m_rd = 1;
                    end
                    if (pc_we) begin
                        case (pc_sel)
                            2'b01: begin
                                if (m_pc == 63) m_wrap = 1;
                                m_pc = (m_pc + 1) % 64;
                            end
                            2'b10: m_pc = int'(gamma);
                            2'b11: m_pc = 0;
                            default: ;
                        endcase
                    end
                end
                ne++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        tot++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 20'(32'h30000 + i * 32'h103);
        mem[0] = 20'h40A05;
        mem[5] = 20'hB1205;
        mem[9] = 20'h7C009;
        tot = 0; bad = 0; chk_en = 0;
        rst = 1; pc_we = 0; pc_sel = 0; gamma = 0; fetch_req = 0;

        tick();
        chk_en = 1;
        tick();
        lit("rst_pc", int'(o_pc[0]), 0);
        lit("rst_instr", int'(o_instr[0]), 0);
        lit("rst_valid", int'(o_valid[0]), 0);
        lit("rst_busy", int'(o_busy[0]), 0);
        lit("rst_rd", int'(o_rd[0]), 0);
        lit("rst_addr", int'(o_addr[0]), 0);
        lit("rst_wrap", int'(o_wrap[0]), 0);
        rst = 0;

        fetch_req = 1; tick();
        lit("f_rd", int'(o_rd[0]), 1);
        lit("f_addr", int'(o_addr[0]), 0);
        lit("f_busy", int'(o_busy[0]), 1);
        fetch_req = 0; tick();
        lit("f_v1", int'(o_valid[0]), 0);
        lit("f_rd_off", int'(o_rd[0]), 0);
        tick();
        lit("f_v2", int'(o_valid[0]), 1);
        lit("f_instr", int'(o_instr[0]), 'h40A05);
        tick();
        lit("f_v3", int'(o_valid[0]), 0);
        lit("f_idle", int'(o_busy[0]), 0);
        repeat (3) tick();

        pc_we = 1; pc_sel = 2'b01; repeat (3) tick();
        lit("pc_inc3", int'(o_pc[0]), 3);
        pc_sel = 2'b10; gamma = 6'd42; tick();
        lit("pc_jmp", int'(o_pc[0]), 42);
        pc_sel = 2'b11; tick();
        lit("pc_rst", int'(o_pc[0]), 0);
        pc_sel = 2'b01; tick();
        lit("pc_inc", int'(o_pc[0]), 1);
        pc_sel = 2'b00; tick();
        lit("pc_hold", int'(o_pc[0]), 1);
        pc_we = 0; pc_sel = 2'b01; tick();
        lit("pc_we0", int'(o_pc[0]), 1);

        pc_we = 1; pc_sel = 2'b10; gamma = 6'd63; tick();
        lit("wr_63", int'(o_pc[0]), 63);
        lit("wr_pre", int'(o_wrap[0]), 0);
        pc_sel = 2'b01; tick();
        lit("wr_pc", int'(o_pc[0]), 0);
        lit("wr_set", int'(o_wrap[0]), 1);
        pc_sel = 2'b10; gamma = 6'd9; tick();
        lit("wr_sticky", int'(o_wrap[0]), 1);
        pc_we = 0;

        fetch_req = 1; tick();
        lit("l3_rd", int'(o_rd[2]), 1);
        lit("l3_addr", int'(o_addr[2]), 9);
        tick();
        lit("l3_rd_off", int'(o_rd[2]), 0);
        lit("l3_busy", int'(o_busy[2]), 1);
        fetch_req = 0; tick();
        lit("l3_v2", int'(o_valid[2]), 0);
        tick();
        lit("l3_v3", int'(o_valid[2]), 0);
        tick();
        lit("l3_v4", int'(o_valid[2]), 1);
        lit("l3_instr", int'(o_instr[2]), 'h7C009);
        tick();
        lit("l3_v5", int'(o_valid[2]), 0);
        lit("l3_idle", int'(o_busy[2]), 0);
        repeat (2) tick();

        pc_we = 1; pc_sel = 2'b10; gamma = 6'd5; tick();
        lit("s_pc5", int'(o_pc[2]), 5);
        fetch_req = 1; gamma = 6'd20; tick();
        lit("s_addr", int'(o_addr[2]), 5);
        lit("s_pc20", int'(o_pc[2]), 20);
        fetch_req = 0; pc_sel = 2'b01; tick();
        tick();
        lit("s_pc22", int'(o_pc[2]), 22);
        lit("s_addr_w", int'(o_addr[2]), 5);
        pc_we = 0; tick();
        tick();
        lit("s_valid", int'(o_valid[2]), 1);
        lit("s_instr", int'(o_instr[2]), 'hB1205);
        repeat (2) tick();

        fetch_req = 1; tick();
        fetch_req = 0; tick();
        tick();
        lit("sv_valid", int'(o_valid[0]), 1);
        fetch_req = 1; tick();
        lit("sv_busy", int'(o_busy[0]), 1);
        lit("sv_rd", int'(o_rd[0]), 1);
        fetch_req = 0;
        repeat (6) tick();

        fetch_req = 1; tick();
        fetch_req = 0; tick();
        lit("rm_busy", int'(o_busy[1]), 1);
        rst = 1; tick();
        lit("rm_valid", int'(o_valid[1]), 0);
        lit("rm_instr", int'(o_instr[1]), 0);
        lit("rm_pc", int'(o_pc[1]), 0);
        lit("rm_idle", int'(o_busy[1]), 0);
        rst = 0; fetch_req = 1; tick();
        lit("rm_rd", int'(o_rd[1]), 1);
        lit("rm_addr", int'(o_addr[1]), 0);
        fetch_req = 0; tick();
        tick();
        lit("rm_v_early", int'(o_valid[1]), 0);
        tick();
        lit("rm_valid2", int'(o_valid[1]), 1);
        lit("rm_instr2", int'(o_instr[1]), 'h40A05);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
